mem_slot_arbiter: RTL and testbench

MEM_SLOT_ARBITER -- requirements
Module: mem_slot_arbiter

---
 rtl/mac_mem_pkg.sv | 17 +
 rtl/mem_slot_arbiter_if.sv | 35 +++
 rtl/mem_slot_timer.sv | 43 ++++
 rtl/mem_slot_arbiter.sv | 87 ++++++++
 tb/tb_mem_slot_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_mem_pkg.sv
// Shared constants and owner codes for the memory slot arbiter.
// Owner codes also select the address mux, so their values are fixed.
package mac_mem_pkg;

   localparam int SLOT_PHASES = 4;
   localparam int PHASE_W     = $clog2(SLOT_PHASES);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      VIDEO    = 3'd1,
      SOUND    = 3'd2,
      DISK_INT = 3'd3,
      DISK_EXT = 3'd4,
      CPU      = 3'd5
   } owner_e;

endpackage

// File: rtl/mem_slot_arbiter_if.sv
// Request, status and strobe bundle between the arbiter and its clients.
// The slave side is the arbiter; the master side drives the requests.
interface mem_slot_arbiter_if;
   import mac_mem_pkg::*;

   logic   clk8_en_p;
   logic   _hblank;
   logic   _vblank;
   logic   cpuReq;
   logic   dskReqInt;
   logic   dskReqExt;

   logic   videoBusControl;
   logic   cpuBusControl;
   owner_e memOwner;
   logic   memoryLatch;
   logic   loadPixels;
   logic   loadSound;
   logic   cpuAck;
   logic   dskReadAckInt;
   logic   dskReadAckExt;

   modport slave (
      input  clk8_en_p, _hblank, _vblank, cpuReq, dskReqInt, dskReqExt,
      output videoBusControl, cpuBusControl, memOwner, memoryLatch,
             loadPixels, loadSound, cpuAck, dskReadAckInt, dskReadAckExt
   );

   modport master (
      output clk8_en_p, _hblank, _vblank, cpuReq, dskReqInt, dskReqExt,
      input  videoBusControl, cpuBusControl, memOwner, memoryLatch,
             loadPixels, loadSound, cpuAck, dskReadAckInt, dskReadAckExt
   );

endinterface

// File: rtl/mem_slot_timer.sv
// Phase counter and video/CPU slot-type bit, stepped by the clk8 enable.
// The first enable after reset only opens slot 0 so the first decision is not delayed.
module mem_slot_timer
   import mac_mem_pkg::*;
(
   input  logic clk32,
   input  logic rst_n,
   input  logic clk8_en_p,
   output logic slot_cpu,
   output logic next_slot_cpu,
   output logic slot_start,
   output logic latch_tick
);

   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SLOT_PHASES - 1);

   logic [PHASE_W-1:0] phase;
   logic               running;
   logic               wrap;

   assign wrap          = running && (phase == PHASE_LAST);
   assign slot_start    = clk8_en_p && (!running || wrap);
   assign latch_tick    = clk8_en_p && wrap;
   assign next_slot_cpu = running ? ~slot_cpu : slot_cpu;

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= '0;
         slot_cpu <= 1'b0;
         running  <= 1'b0;
      end else if (clk8_en_p) begin
         if (!running) begin
            running <= 1'b1;
         end else begin
            phase <= wrap ? '0 : phase + 1'b1;
            if (wrap) begin
               slot_cpu <= ~slot_cpu;
            end
         end
      end
   end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Slot arbiter: commits one memory owner per 4-phase slot and emits the
// latch strobe plus the owner's completion strobe at the end of the slot.
module mem_slot_arbiter
   import mac_mem_pkg::*;
(
   input  logic               clk32,
   input  logic               _systemReset,
   mem_slot_arbiter_if.slave  bus
);

   logic   slot_cpu;
   logic   next_slot_cpu;
   logic   slot_start;
   logic   latch_tick;

   owner_e owner;
   owner_e next_owner;
   logic   hblank_d;
   logic   hblank_fall;
   logic   sound_pending;
   logic   prefer_ext;
   logic   latch;

   mem_slot_timer u_timer (
      .clk32         (clk32),
      .rst_n         (_systemReset),
      .clk8_en_p     (bus.clk8_en_p),
      .slot_cpu      (slot_cpu),
      .next_slot_cpu (next_slot_cpu),
      .slot_start    (slot_start),
      .latch_tick    (latch_tick)
   );

   assign hblank_fall = hblank_d && !bus._hblank;

   always_comb begin
      next_owner = IDLE;
      if (next_slot_cpu) begin
         next_owner = bus.cpuReq ? CPU : IDLE;
      end else if (bus._hblank && bus._vblank) begin
         next_owner = VIDEO;
      end else if (sound_pending) begin
         next_owner = SOUND;
      end else if (bus.dskReqInt && bus.dskReqExt) begin
         next_owner = prefer_ext ? DISK_EXT : DISK_INT;
      end else if (bus.dskReqInt) begin
         next_owner = DISK_INT;
      end else if (bus.dskReqExt) begin
         next_owner = DISK_EXT;
      end
   end

   always_ff @(posedge clk32 or negedge _systemReset) begin
      if (!_systemReset) begin
         owner         <= IDLE;
         hblank_d      <= 1'b1;
         sound_pending <= 1'b0;
         prefer_ext    <= 1'b0;
      end else begin
         hblank_d <= bus._hblank;
         // a fresh hblank fall wins over the clear of a sound slot committed the same cycle
         sound_pending <= hblank_fall ||
                          (sound_pending && !(slot_start && next_owner == SOUND));
         if (slot_start) begin
            owner <= next_owner;
            if (next_owner == DISK_INT) begin
               prefer_ext <= 1'b1;
            end else if (next_owner == DISK_EXT) begin
               prefer_ext <= 1'b0;
            end
         end
      end
   end

   assign latch = latch_tick && (owner != IDLE);

   assign bus.memoryLatch     = latch;
   assign bus.loadPixels      = latch && (owner == VIDEO);
   assign bus.loadSound       = latch && (owner == SOUND);
   assign bus.cpuAck          = latch && (owner == CPU) && bus.cpuReq;
   assign bus.dskReadAckInt   = latch && (owner == DISK_INT) && bus.dskReqInt;
   assign bus.dskReadAckExt   = latch && (owner == DISK_EXT) && bus.dskReqExt;
   assign bus.memOwner        = owner;
   assign bus.videoBusControl = ~slot_cpu;
   assign bus.cpuBusControl   = slot_cpu;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Scoreboard bench: a slot-level reference model predicts every strobe and a
// negedge monitor compares what the arbiter presents.
module tb_mem_slot_arbiter;
   import mac_mem_pkg::*;

   logic clk32 = 1'b0;
   logic rst_n = 1'b0;

   mem_slot_arbiter_if bus ();

   mem_slot_arbiter dut (
      .clk32        (clk32),
      ._systemReset (rst_n),
      .bus          (bus.slave)
   );

   always #15 clk32 = ~clk32;

   typedef struct {
      int         cyc;
      owner_e     owner;
      bit         cpu_slot;
      logic [4:0] strobes;   // {pixels, sound, cpuAck, ackInt, ackExt}
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   bit s_rst = 0, s_hb = 1, s_vb = 1, s_cpu = 0, s_di = 0, s_de = 0;
   bit auto_drop = 0;

   // reference model state: slot-level view
   bit     m_started;
   int     m_tick;
   owner_e m_owner;
   bit     m_pend;
   bit     m_last_ext;
   bit     m_hb_prev;
   int     m_dec_cyc;
   bit     m_dec_cpu;

   function automatic owner_e ref_owner(bit cpu_slot);
      if (cpu_slot) return s_cpu ? CPU : IDLE;
      if (s_hb && s_vb) return VIDEO;
      if (m_pend) return SOUND;
      if (s_di && s_de) return m_last_ext ? DISK_INT : DISK_EXT;
      if (s_di) return DISK_INT;
      if (s_de) return DISK_EXT;
      return IDLE;
   endfunction

   task automatic model_reset();
      m_started = 0; m_tick = 0; m_owner = IDLE; m_pend = 0;
      m_last_ext = 1; m_hb_prev = 1; m_dec_cyc = -1; m_dec_cpu = 0;
   endtask

   task automatic model_eval();
      bit     fall;
      exp_t   e;
      owner_e nxt;
      int     slot;
      if (!s_rst) begin
         model_reset();
         return;
      end
      fall = m_hb_prev && !s_hb;
      if (bus.clk8_en_p) begin
         if (m_started && (m_tick % 4 == 3) && m_owner != IDLE) begin
            e.cyc      = cyc;
            e.owner    = m_owner;
            e.cpu_slot = ((m_tick / 4) % 2) == 1;
            e.strobes  = {m_owner == VIDEO, m_owner == SOUND,
                          m_owner == CPU && s_cpu,
                          m_owner == DISK_INT && s_di,
                          m_owner == DISK_EXT && s_de};
            sb.push_back(e);
            if (auto_drop) begin
               if (e.strobes[2]) s_cpu = 0;
               if (e.strobes[1]) s_di = 0;
               if (e.strobes[0]) s_de = 0;
            end
         end
         if (!m_started || (m_tick % 4 == 3)) begin
            slot = m_started ? (m_tick + 1) / 4 : 0;
            nxt  = ref_owner((slot % 2) == 1);
            if (nxt == SOUND) m_pend = 0;
            if (nxt == DISK_INT) m_last_ext = 0;
            if (nxt == DISK_EXT) m_last_ext = 1;
            m_owner   = nxt;
            m_dec_cyc = cyc;
            m_dec_cpu = (slot % 2) == 1;
         end
         if (m_started) m_tick++;
         else m_started = 1;
      end
      if (fall) m_pend = 1;
      m_hb_prev = s_hb;
   endtask

   task automatic step();
      @(posedge clk32);
      #1;
      cyc++;
      rst_n         = s_rst;
      bus.clk8_en_p = (cyc % 4 == 0);
      bus._hblank   = s_hb;
      bus._vblank   = s_vb;
      bus.cpuReq    = s_cpu;
      bus.dskReqInt = s_di;
      bus.dskReqExt = s_de;
      model_eval();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return m_started && m_owner == CPU && (m_tick % 4 == 2);
         1:       return m_dec_cyc == cyc && m_dec_cpu;
         2:       return m_started && m_owner == DISK_EXT && (m_tick % 4 == 1);
         3:       return m_started && m_owner == DISK_EXT && (m_tick % 4 == 2);
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int which, input string name);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (cond(which)) begin
            ok = 1;
            break;
         end
         step();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_%s: condition not reached, got timeout, want reached within 400 cycles", name);
      end
   endtask

   task automatic check_reset(input string name);
      @(negedge clk32);
      checks++;
      if (bus.videoBusControl !== 1'b1 || bus.cpuBusControl !== 1'b0 ||
          bus.memOwner !== IDLE || bus.memoryLatch !== 1'b0 ||
          {bus.loadPixels, bus.loadSound, bus.cpuAck,
           bus.dskReadAckInt, bus.dskReadAckExt} !== 5'b0) begin
         errors++;
         $display("FAIL reset_%s: got vbc=%b cbc=%b owner=%0d latch=%b strobes=%b, want vbc=1 cbc=0 owner=0 latch=0 strobes=00000",
                  name, bus.videoBusControl, bus.cpuBusControl, bus.memOwner, bus.memoryLatch,
                  {bus.loadPixels, bus.loadSound, bus.cpuAck, bus.dskReadAckInt, bus.dskReadAckExt});
      end
   endtask

   // monitor
   logic [4:0] got;
   exp_t       e_mon;
   always @(negedge clk32) begin
      got = {bus.loadPixels, bus.loadSound, bus.cpuAck, bus.dskReadAckInt, bus.dskReadAckExt};
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e_mon = sb.pop_front();
         checks++;
         if (bus.memoryLatch !== 1'b1 || got !== e_mon.strobes ||
             bus.memOwner !== e_mon.owner || bus.cpuBusControl !== e_mon.cpu_slot) begin
            errors++;
            $display("FAIL strobe cyc=%0d: got latch=%b owner=%0d strobes=%b cpuslot=%b, want latch=1 owner=%0d strobes=%b cpuslot=%b",
                     cyc, bus.memoryLatch, bus.memOwner, got, bus.cpuBusControl,
                     e_mon.owner, e_mon.strobes, e_mon.cpu_slot);
         end
      end else if (bus.memoryLatch || got != 5'b0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_strobe cyc=%0d: got latch=%b owner=%0d strobes=%b, want no strobe",
                  cyc, bus.memoryLatch, bus.memOwner, got);
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int raise_cyc, ack_cyc;

   initial begin
      bus.clk8_en_p = 0; bus._hblank = 1; bus._vblank = 1;
      bus.cpuReq = 0; bus.dskReqInt = 0; bus.dskReqExt = 0;
      model_reset();

      // reset values
      steps(3);
      check_reset("initial");
      steps(2);
      check_reset("held");
      s_rst = 1;

      // active display, CPU request held: pixels and CPU acks alternate
      s_cpu = 1;
      steps(200);

      // CPU request dropped in phase 2: latch without ack
      wait_for(0, "cpu_phase2");
      s_cpu = 0;
      steps(40);

      // request raised one tick after an idle CPU decision: ack 11 ticks later
      wait_for(1, "cpu_decision");
      steps(3);
      s_cpu = 1;
      auto_drop = 1;
      step();
      raise_cyc = cyc;
      ack_cyc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk32);
         if (bus.cpuAck) begin
            ack_cyc = cyc;
            break;
         end
         step();
      end
      checks++;
      if (ack_cyc - raise_cyc != 44) begin
         errors++;
         $display("FAIL cpu_latency: got %0d clk32 cycles, want 44 (11 clk8 ticks)", ack_cyc - raise_cyc);
      end
      steps(8);

      // hblank falls with internal disk pending: sound slot then disk slot
      s_di = 1;
      s_hb = 0;
      steps(96);
      s_hb = 1;
      steps(16);

      // vertical blanking, both disks held: round-robin Int/Ext
      auto_drop = 0;
      s_vb = 0; s_di = 1; s_de = 1;
      steps(160);

      // reset during phase 2 of an external-disk slot with a sound request pending
      s_di = 0;
      wait_for(2, "ext_phase1");
      s_hb = 0;
      step();
      wait_for(3, "ext_phase2");
      s_rst = 0;
      step();
      check_reset("midslot");
      s_hb = 1;
      steps(2);
      check_reset("midslot_held");
      s_rst = 1;
      steps(80);

      // randomized traffic
      auto_drop = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 2) s_hb = ~s_hb;
         if ($urandom_range(0, 99) < 1) s_vb = ~s_vb;
         if (!s_cpu && $urandom_range(0, 99) < 5) s_cpu = 1;
         else if (s_cpu && $urandom_range(0, 999) < 3) s_cpu = 0;
         if (!s_di && $urandom_range(0, 99) < 3) s_di = 1;
         else if (s_di && $urandom_range(0, 999) < 3) s_di = 0;
         if (!s_de && $urandom_range(0, 99) < 3) s_de = 1;
         else if (s_de && $urandom_range(0, 999) < 3) s_de = 0;
         if ($urandom_range(0, 1499) == 0) begin
            s_rst = 0;
            steps(2);
            s_rst = 1;
         end
         step();
      end

      s_cpu = 0; s_di = 0; s_de = 0;
      steps(40);
      @(negedge clk32);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
